// File: rtl/motion_arbiter.sv
// motion_arbiter: obstacle-avoidance arbiter for a small IR-controlled rover.
// IR commands and the ambient-light flag are synchronized and debounced,
// too_close is debounced only. A single FSM either follows the debounced
// drive commands or runs a timed avoidance manoeuvre: halt, right turn,
// then a settle window in which the obstacle flag is ignored.
module motion_arbiter #(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int STOP_CYC     = 200000,
    parameter int TURN_CYC     = 600000,
    parameter int SETTLE_CYC   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_up,
    input  logic       ir_left,
    input  logic       ir_right,
    input  logic       too_close,
    input  logic       dark,
    output logic       forward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       turning,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_STOP   = 2'd1,
        ST_TURN   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // A zero-length interval behaves as a single cycle.
    localparam int DB_N     = (DEBOUNCE_CYC == 0) ? 1 : DEBOUNCE_CYC;
    localparam int STOP_N   = (STOP_CYC     == 0) ? 1 : STOP_CYC;
    localparam int TURN_N   = (TURN_CYC     == 0) ? 1 : TURN_CYC;
    localparam int SETTLE_N = (SETTLE_CYC   == 0) ? 1 : SETTLE_CYC;

    localparam logic [23:0] DB_LAST     = 24'(DB_N - 1);
    localparam logic [23:0] STOP_LAST   = 24'(STOP_N - 1);
    localparam logic [23:0] TURN_LAST   = 24'(TURN_N - 1);
    localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_N - 1);

    // Debounced level bit positions.
    localparam int B_CLOSE = 0;
    localparam int B_UP    = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_DARK  = 4;

    // Motion vector layout: {forward, turn_left, turn_right}.
    localparam logic [2:0] MOT_NONE  = 3'b000;
    localparam logic [2:0] MOT_RIGHT = 3'b001;

    logic [3:0]  async_in_s;
    logic [3:0]  sync1_r;
    logic [3:0]  sync2_r;
    logic [4:0]  db_in_s;
    logic [4:0]  level_r;
    logic [23:0] db_cnt_r [5];

    state_t      state_r;
    logic [23:0] cnt_r;
    logic [2:0]  motion_r;
    logic        turning_r;

    // Priority decode of debounced commands; the result is one-hot or zero.
    function automatic logic [2:0] drive_decode(input logic up, input logic left,
                                                input logic right, input logic is_dark);
        logic [2:0] m;
        m = 3'b000;
        if (is_dark) begin
            m = 3'b000;
        end else if (left && right) begin
            m = 3'b000;
        end else if (left) begin
            m = 3'b010;
        end else if (right) begin
            m = 3'b001;
        end else if (up) begin
            m = 3'b100;
        end else begin
            m = 3'b000;
        end
        return m;
    endfunction

    assign async_in_s = {dark, ir_right, ir_left, ir_up};
    assign db_in_s    = {sync2_r, too_close};

    // Two-flop synchronizer for the asynchronous command and light inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= async_in_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-input debouncer: accept a new level after DB_N consecutive samples,
    // any sample equal to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                db_cnt_r[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (db_in_s[i] == level_r[i]) begin
                    db_cnt_r[i] <= 24'd0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    level_r[i]  <= db_in_s[i];
                    db_cnt_r[i] <= 24'd0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 24'd1;
                end
            end
        end
    end

    // Arbiter FSM; outputs are registered and computed for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_DRIVE;
            cnt_r     <= 24'd0;
            motion_r  <= MOT_NONE;
            turning_r <= 1'b0;
        end else begin
            case (state_r)
                ST_DRIVE: begin
                    cnt_r <= 24'd0;
                    if (level_r[B_CLOSE]) begin
                        state_r   <= ST_STOP;
                        motion_r  <= MOT_NONE;
                        turning_r <= 1'b1;
                    end else begin
                        state_r   <= ST_DRIVE;
                        motion_r  <= drive_decode(level_r[B_UP], level_r[B_LEFT],
                                                  level_r[B_RIGHT], level_r[B_DARK]);
                        turning_r <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == STOP_LAST) begin
                        state_r   <= ST_TURN;
                        cnt_r     <= 24'd0;
                        motion_r  <= MOT_RIGHT;
                        turning_r <= 1'b1;
                    end else begin
                        state_r   <= ST_STOP;
                        cnt_r     <= cnt_r + 24'd1;
                        motion_r  <= MOT_NONE;
                        turning_r <= 1'b1;
                    end
                end
                ST_TURN: begin
                    if (cnt_r == TURN_LAST) begin
                        state_r   <= ST_SETTLE;
                        cnt_r     <= 24'd0;
                        motion_r  <= drive_decode(level_r[B_UP], level_r[B_LEFT],
                                                  level_r[B_RIGHT], level_r[B_DARK]);
                        turning_r <= 1'b0;
                    end else begin
                        state_r   <= ST_TURN;
                        cnt_r     <= cnt_r + 24'd1;
                        motion_r  <= MOT_RIGHT;
                        turning_r <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // too_close is deliberately ignored here.
                    motion_r  <= drive_decode(level_r[B_UP], level_r[B_LEFT],
                                              level_r[B_RIGHT], level_r[B_DARK]);
                    turning_r <= 1'b0;
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= ST_DRIVE;
                        cnt_r   <= 24'd0;
                    end else begin
                        state_r <= ST_SETTLE;
                        cnt_r   <= cnt_r + 24'd1;
                    end
                end
                default: begin
                    state_r   <= ST_DRIVE;
                    cnt_r     <= 24'd0;
                    motion_r  <= MOT_NONE;
                    turning_r <= 1'b0;
                end
            endcase
        end
    end

    assign forward    = motion_r[2];
    assign turn_left  = motion_r[1];
    assign turn_right = motion_r[0];
    assign turning    = turning_r;
    assign state_dbg  = state_r;

endmodule

// File: tb/tb_motion_arbiter.sv
// Self-checking bench for motion_arbiter with short timing parameters.
// A time-indexed reference model checks every cycle; directed tables and
// sequences pin the documented latencies and manoeuvre shape.
module tb_motion_arbiter;

    localparam int D  = 4;
    localparam int S  = 5;
    localparam int T  = 8;
    localparam int ST = 3;
    localparam int NH = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_up, ir_left, ir_right, too_close, dark;
    logic       forward, turn_left, turn_right, turning;
    logic [1:0] state_dbg;

    motion_arbiter #(
        .DEBOUNCE_CYC(D), .STOP_CYC(S), .TURN_CYC(T), .SETTLE_CYC(ST)
    ) dut (
        .clk(clk), .reset(reset),
        .ir_up(ir_up), .ir_left(ir_left), .ir_right(ir_right),
        .too_close(too_close), .dark(dark),
        .forward(forward), .turn_left(turn_left), .turn_right(turn_right),
        .turning(turning), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // History indexed by clock edge: inputs present at edge k, reset at edge k,
    // debounced levels after edge k. Bits: 0 close, 1 up, 2 left, 3 right, 4 dark.
    logic [4:0] in_h  [NH];
    logic       rst_h [NH];
    logic [4:0] lvl_h [NH];
    int         mstart = -1;   // edge at which the current manoeuvre began
    logic [5:0] exp_pack;

    typedef struct {
        logic       up, left, right, dk;
        logic [2:0] mot;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_decode(input logic [4:0] l);
        if (l[4])              return 3'b000;
        if (l[2] && l[3])      return 3'b000;
        if (l[2])              return 3'b010;
        if (l[3])              return 3'b001;
        if (l[1])              return 3'b100;
        return 3'b000;
    endfunction

    // Sample the debouncer sees at edge k.
    function automatic logic dbin(input int k, input int b);
        if (b == 0) return in_h[k][0];
        if (k < 2) return 1'b0;
        if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
        return in_h[k-2][b];
    endfunction

    // Phase after edge k from elapsed time since manoeuvre start.
    function automatic int phase_of(input int k);
        int e;
        e = k - mstart;
        if (mstart < 0 || e < 0 || e >= S + T + ST) return 0;
        if (e < S) return 1;
        if (e < S + T) return 2;
        return 3;
    endfunction

    task automatic model_step(input int k);
        int ph;
        logic v, all_same;
        for (int b = 0; b < 5; b++) begin
            if (rst_h[k]) begin
                lvl_h[k][b] = 1'b0;
            end else begin
                v = dbin(k, b);
                all_same = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (k - j < 1) all_same = 1'b0;
                    else if (rst_h[k-j] || dbin(k - j, b) != v) all_same = 1'b0;
                end
                lvl_h[k][b] = (all_same && v != lvl_h[k-1][b]) ? v : lvl_h[k-1][b];
            end
        end
        if (rst_h[k]) mstart = -1;
        else if (phase_of(k - 1) == 0 && lvl_h[k-1][0]) mstart = k;
        ph = phase_of(k);
        if (rst_h[k])     exp_pack = 6'b000000;
        else if (ph == 1) exp_pack = {2'd1, 1'b1, 3'b000};
        else if (ph == 2) exp_pack = {2'd2, 1'b1, 3'b001};
        else              exp_pack = {2'(ph), 1'b0, ref_decode(lvl_h[k-1])};
    endtask

    task automatic tick();
        if (cyc + 1 >= NH) begin
            $display("FAIL history_overflow cycle=%0d actual=%0d expected<%0d", cyc, cyc + 1, NH);
            $fatal(1, "history overflow");
        end
        in_h[cyc+1]  = {dark, ir_right, ir_left, ir_up, too_close};
        rst_h[cyc+1] = reset;
        @(posedge clk);
        #1;
        cyc++;
        model_step(cyc);
        check("model", {state_dbg, turning, forward, turn_left, turn_right}, exp_pack);
        check("onehot", ($countones({forward, turn_left, turn_right}) <= 1) ? 1 : 0, 1);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [5:0] outs();
        return {state_dbg, turning, forward, turn_left, turn_right};
    endfunction

    vec_t vecs [10];
    logic [5:0] e;
    logic       seen;

    initial begin
        in_h[0] = 5'b0; rst_h[0] = 1'b1; lvl_h[0] = 5'b0;
        reset = 1'b1; ir_up = 1'b0; ir_left = 1'b0; ir_right = 1'b0;
        too_close = 1'b0; dark = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100};

        // Reset state.
        tick_n(3);
        check("reset_outputs", outs(), 6'b000000);
        reset = 1'b0;
        tick_n(10);

        // Forward latency from a clean ir_up edge.
        ir_up = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check("fwd_latency", forward, (j == 7) ? 1 : 0);
        end
        ir_up = 1'b0;
        tick_n(10);

        // A 3-cycle pulse must be rejected.
        seen = 1'b0;
        ir_up = 1'b1;
        tick_n(3);
        ir_up = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (forward) seen = 1'b1;
        end
        check("pulse_reject", seen, 1'b0);

        // Command priority table.
        for (int v = 0; v < 10; v++) begin
            ir_up = vecs[v].up; ir_left = vecs[v].left;
            ir_right = vecs[v].right; dark = vecs[v].dk;
            tick_n(10);
            check("decode_table", {forward, turn_left, turn_right}, vecs[v].mot);
        end

        // Full avoidance manoeuvre from forward motion.
        too_close = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i <= 4)       e = 6'b000100;
            else if (i <= 9)  e = 6'b011000;
            else if (i <= 17) e = 6'b101001;
            else if (i <= 20) e = 6'b110100;
            else              e = 6'b000100;
            check("avoid_seq", outs(), e);
            if (i == 5) too_close = 1'b0;
        end

        // Dark during TURN: turn completes, no forward afterwards.
        too_close = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (i <= 4)       e = 6'b000100;
            else if (i <= 9)  e = 6'b011000;
            else if (i <= 17) e = 6'b101001;
            else if (i <= 20) e = 6'b110000;
            else              e = 6'b000000;
            check("dark_in_turn", outs(), e);
            if (i == 5)  too_close = 1'b0;
            if (i == 11) dark = 1'b1;
        end
        dark = 1'b0;
        tick_n(12);
        check("dark_release", forward, 1'b1);

        // Continuous obstacle: manoeuvres repeat with one DRIVE cycle between.
        too_close = 1'b1;
        for (int i = 1; i <= 56; i++) begin
            tick();
            if (i >= 5) begin
                int p;
                p = (i - 5) % 17;
                check("repeat_state", state_dbg,
                      (p < 5) ? 1 : (p < 13) ? 2 : (p < 16) ? 3 : 0);
            end
        end
        too_close = 1'b0;
        tick_n(40);

        // Reset mid-turn aborts; forward returns after the full pipeline latency.
        too_close = 1'b1;
        tick_n(5);
        too_close = 1'b0;
        tick_n(7);
        check("in_turn", state_dbg, 2'd2);
        reset = 1'b1;
        tick();
        check("reset_abort", outs(), 6'b000000);
        reset = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check("resume_latency", outs(), (j == 7) ? 6'b000100 : 6'b000000);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) ir_up    = ~ir_up;
            if ($urandom_range(0, 15) == 0) ir_left  = ~ir_left;
            if ($urandom_range(0, 15) == 0) ir_right = ~ir_right;
            if ($urandom_range(0, 31) == 0) dark     = ~dark;
            if ($urandom_range(0, 19) == 0) too_close = ~too_close;
            reset = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_arbiter.md
MOTION_ARBITER -- requirements
Module: motion_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYC, default 1000, SHALL set the consecutive stable cycles required to accept a new level on any command or sensor input (1 ms at the 1 MHz tick).
REQ-003 Parameter STOP_CYC, default 200000, SHALL set the avoidance halt duration in cycles.
REQ-004 Parameter TURN_CYC, default 600000, SHALL set the avoidance right-turn duration in cycles (approximately 90 degrees).
REQ-005 Parameter SETTLE_CYC, default 100000, SHALL set the post-turn hold-off during which too_close is ignored.
REQ-006 clk, input, 1 bit: 1 MHz divided system clock.
REQ-007 reset, input, 1 bit: synchronous active-high reset.
REQ-008 ir_up, ir_left, ir_right, input, 1 bit each: asynchronous level commands from the IR decoder.
REQ-009 too_close, input, 1 bit: clk-domain obstacle flag from the ultrasonic stage.
REQ-010 dark, input, 1 bit: asynchronous ambient-light flag from the photoresistor stage.
REQ-011 forward, turn_left, turn_right, output, 1 bit each: registered drive commands to the motor stage.
REQ-012 turning, output, 1 bit: high while an avoidance manoeuvre is in progress, for the speaker stage.
REQ-013 state_dbg, output, 2 bits: current FSM state encoding, with DRIVE=0, STOP=1, TURN=2, SETTLE=3.

Function
REQ-014 ir_up, ir_left, ir_right and dark SHALL each pass through a 2-flop synchronizer before debounce; too_close SHALL NOT be synchronized.
REQ-015 Each input SHALL have an independent debouncer whose accepted level changes only after DEBOUNCE_CYC consecutive samples of the new level; any glitch SHALL restart that debouncer's count.
REQ-016 Total latency from a clean ir_* or dark edge to the output change SHALL be exactly DEBOUNCE_CYC+3 cycles; for too_close it SHALL be exactly DEBOUNCE_CYC+1 cycles.
REQ-017 In DRIVE, the outputs SHALL decode from debounced commands with this priority:
- dark=1 -> all motion outputs 0
- left and right both 1 -> all 0
- left only -> turn_left
- right only -> turn_right
- otherwise up -> forward
- else -> all 0
REQ-018 Motion outputs SHALL be mutually exclusive (at most one high) in every cycle, including reset.
REQ-019 DRIVE -> STOP SHALL occur when debounced too_close=1, regardless of dark or commands; the counter SHALL load 0.
REQ-020 STOP SHALL hold all motion outputs at 0 for STOP_CYC cycles, then transition to TURN.
REQ-021 TURN SHALL assert turn_right only, for TURN_CYC cycles, then transition to SETTLE.
REQ-022 SETTLE SHALL apply the DRIVE decode for SETTLE_CYC cycles while ignoring too_close, then return to DRIVE.
REQ-023 turning SHALL be 1 in STOP and TURN and 0 in DRIVE and SETTLE.
REQ-024 IR commands and dark SHALL have no effect in STOP or TURN; an avoidance manoeuvre, once started, SHALL always complete.
REQ-025 If too_close is still 1 on entry to DRIVE from SETTLE, the FSM SHALL enter STOP on the next cycle, so repeated manoeuvres are allowed.
REQ-026 The state counter SHALL be 24 bits, SHALL count from 0 to N-1 within each timed state, and SHALL reset to 0 on every state change.
REQ-027 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-028 While reset=1, the FSM SHALL be forced to DRIVE, all counters and debouncers SHALL clear, and all debounced levels SHALL become 0.
REQ-029 During reset, forward, turn_left, turn_right and turning SHALL be 0 and state_dbg SHALL be 0.
REQ-030 Reset asserted mid-manoeuvre SHALL abort it on the same edge; the first cycle after reset SHALL be in DRIVE with outputs 0.

Verification
All scenarios use DEBOUNCE_CYC=4, STOP_CYC=5, TURN_CYC=8, SETTLE_CYC=3.
REQ-031 ir_up held high from cycle 0 -> forward rises at cycle 7; a 3-cycle ir_up pulse -> forward never rises.
REQ-032 ir_up and ir_left both high -> only turn_left is asserted; ir_left and ir_right both high -> all motion outputs 0.
REQ-033 too_close high while forward=1 -> 5 cycles all 0 with turning=1, then 8 cycles turn_right=1 with turning=1, then 3 cycles of DRIVE decode with turning=0, then DRIVE.
REQ-034 dark asserted during TURN -> turn_right continues for the full 8 cycles; forward=0 after SETTLE while dark=1.
REQ-035 too_close held continuously -> STOP/TURN/SETTLE repeats with exactly one DRIVE cycle between manoeuvres.
REQ-036 reset pulsed during TURN -> next cycle state_dbg=0 and all outputs 0; forward resumes 7 cycles after reset deasserts, with ir_up held high.
